// File: rtl/dmx_frame_sequencer.sv
// DMX512 frame sequencer: emits BREAK, MAB, start code, N slot bytes and an
// inter-frame mark, fetching slot bytes from an external one-cycle-latency memory.
//
// Ports:
//   CLK12      - system clock, all logic on rising edge
//   RESET      - synchronous active-high reset
//   enable     - level; frames are sent back-to-back while high
//   num_slots  - slots per frame (clamped to 512), sampled at frame start
//   start_code - start-code byte, sampled at frame start
//   slot_rd    - one-cycle read strobe to slot memory
//   slot_addr  - slot index 0..511, held between strobes
//   slot_data  - slot value, valid exactly one cycle after slot_rd
//   dmx_data   - registered line level (1 = mark/idle)
//   busy       - high whenever not idle
//   frame_done - one-cycle pulse after the last stop bit of a frame
module dmx_frame_sequencer #(
    parameter int unsigned CLK_HZ     = 12_000_000,
    parameter int unsigned BAUD       = 250_000,
    parameter int unsigned BREAK_BITS = 24,
    parameter int unsigned MAB_BITS   = 3,
    parameter int unsigned MTBF_BITS  = 2
) (
    input  logic       CLK12,
    input  logic       RESET,
    input  logic       enable,
    input  logic [9:0] num_slots,
    input  logic [7:0] start_code,
    output logic       slot_rd,
    output logic [8:0] slot_addr,
    input  logic [7:0] slot_data,
    output logic       dmx_data,
    output logic       busy,
    output logic       frame_done
);

    // BIT_CYCLES must be at least 2 so the slot capture lands inside the start bit.
    localparam int unsigned BIT_CYCLES = CLK_HZ / BAUD;
    localparam int unsigned TMR_W      = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned BYTE_BITS  = 11;
    localparam int unsigned BN_MAX_A   = (BREAK_BITS > MAB_BITS) ? BREAK_BITS : MAB_BITS;
    localparam int unsigned BN_MAX_B   = (MTBF_BITS > BYTE_BITS) ? MTBF_BITS : BYTE_BITS;
    localparam int unsigned BN_MAX     = (BN_MAX_A > BN_MAX_B) ? BN_MAX_A : BN_MAX_B;
    localparam int unsigned BN_W       = $clog2(BN_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BREAK,
        S_MAB,
        S_BYTE,
        S_MTBF
    } state_t;

    state_t            state, state_nx;
    logic [TMR_W-1:0]  tmr, tmr_nx;
    logic [BN_W-1:0]   bit_num, bit_nx;
    logic [9:0]        byte_idx, byte_nx;
    logic [9:0]        slots_q;
    logic [7:0]        sc_q;
    logic [7:0]        slot_q;

    logic              bit_end;
    logic              frame_start;
    logic              capture_now;
    logic [9:0]        slots_clamped;
    logic [7:0]        cur_byte;

    logic              dmx_d;
    logic              rd_d;
    logic [8:0]        addr_d;
    logic              done_d;
    logic              busy_d;

    assign bit_end       = (tmr == TMR_W'(BIT_CYCLES - 1));
    assign frame_start   = (state_nx == S_BREAK) && (state != S_BREAK);
    assign slots_clamped = (num_slots > 10'd512) ? 10'd512 : num_slots;
    // Memory data is valid in the second clock of a slot byte's start bit.
    assign capture_now   = (state == S_BYTE) && (bit_num == '0) &&
                           (tmr == TMR_W'(1)) && (byte_idx != '0);

    // State register
    always_ff @(posedge CLK12) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and bit/byte timing; the bit timer restarts at every state entry
    always_comb begin
        state_nx = state;
        tmr_nx   = tmr + TMR_W'(1);
        bit_nx   = bit_num;
        byte_nx  = byte_idx;
        if (bit_end) begin
            tmr_nx = '0;
            bit_nx = bit_num + BN_W'(1);
        end
        case (state)
            S_IDLE: begin
                tmr_nx  = '0;
                bit_nx  = '0;
                byte_nx = '0;
                if (enable) begin
                    state_nx = S_BREAK;
                end
            end
            S_BREAK: begin
                if (bit_end && bit_num == BN_W'(BREAK_BITS - 1)) begin
                    state_nx = S_MAB;
                    bit_nx   = '0;
                end
            end
            S_MAB: begin
                if (bit_end && bit_num == BN_W'(MAB_BITS - 1)) begin
                    state_nx = S_BYTE;
                    bit_nx   = '0;
                    byte_nx  = '0;
                end
            end
            S_BYTE: begin
                if (bit_end && bit_num == BN_W'(BYTE_BITS - 1)) begin
                    bit_nx = '0;
                    if (byte_idx == slots_q) begin
                        state_nx = S_MTBF;
                    end else begin
                        byte_nx = byte_idx + 10'd1;
                    end
                end
            end
            S_MTBF: begin
                if (bit_end && bit_num == BN_W'(MTBF_BITS - 1)) begin
                    bit_nx   = '0;
                    byte_nx  = '0;
                    state_nx = enable ? S_BREAK : S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
                tmr_nx   = '0;
                bit_nx   = '0;
                byte_nx  = '0;
            end
        endcase
    end

    // Timing counters and latched frame parameters
    always_ff @(posedge CLK12) begin
        if (RESET) begin
            tmr      <= '0;
            bit_num  <= '0;
            byte_idx <= '0;
            slots_q  <= '0;
            sc_q     <= '0;
            slot_q   <= '0;
        end else begin
            tmr      <= tmr_nx;
            bit_num  <= bit_nx;
            byte_idx <= byte_nx;
            if (frame_start) begin
                slots_q <= slots_clamped;
                sc_q    <= start_code;
            end
            if (capture_now) begin
                slot_q <= slot_data;
            end
        end
    end

    // Bypass keeps the first data bit correct even when the capture edge ends bit 0.
    assign cur_byte = (byte_nx == '0) ? sc_q : (capture_now ? slot_data : slot_q);

    // Output decode from the upcoming state so every output is registered
    always_comb begin
        dmx_d  = 1'b1;
        rd_d   = 1'b0;
        addr_d = slot_addr;
        done_d = (state == S_BYTE) && (state_nx == S_MTBF);
        busy_d = (state_nx != S_IDLE);
        case (state_nx)
            S_BREAK: dmx_d = 1'b0;
            S_BYTE: begin
                if (bit_nx == '0) begin
                    dmx_d = 1'b0;
                end else if (bit_nx <= BN_W'(8)) begin
                    dmx_d = cur_byte[3'(bit_nx - BN_W'(1))];
                end
                if (bit_nx == '0 && tmr_nx == '0 && byte_nx != '0) begin
                    rd_d   = 1'b1;
                    addr_d = 9'(byte_nx - 10'd1);
                end
            end
            default: dmx_d = 1'b1;
        endcase
    end

    // Output register
    always_ff @(posedge CLK12) begin
        if (RESET) begin
            dmx_data   <= 1'b1;
            slot_rd    <= 1'b0;
            slot_addr  <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            dmx_data   <= dmx_d;
            slot_rd    <= rd_d;
            slot_addr  <= addr_d;
            frame_done <= done_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_dmx_frame_sequencer.sv
// Directed bench for dmx_frame_sequencer, run at 4 clocks per bit to keep
// 512-slot frames short.
module tb_dmx_frame_sequencer;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned BAUD   = 250_000;
    localparam int unsigned BC     = 4;
    localparam int unsigned BRK    = 24;
    localparam int unsigned MAB    = 3;
    localparam int unsigned MTBF   = 2;

    logic       CLK12 = 1'b0;
    logic       RESET;
    logic       enable;
    logic [9:0] num_slots;
    logic [7:0] start_code;
    logic       slot_rd;
    logic [8:0] slot_addr;
    logic [7:0] slot_data;
    logic       dmx_data;
    logic       busy;
    logic       frame_done;

    logic [7:0] mem [512];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rd_cnt   = 0;
    int done_cnt = 0;

    dmx_frame_sequencer #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .BREAK_BITS(BRK),
        .MAB_BITS  (MAB),
        .MTBF_BITS (MTBF)
    ) dut (
        .CLK12     (CLK12),
        .RESET     (RESET),
        .enable    (enable),
        .num_slots (num_slots),
        .start_code(start_code),
        .slot_rd   (slot_rd),
        .slot_addr (slot_addr),
        .slot_data (slot_data),
        .dmx_data  (dmx_data),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 CLK12 = ~CLK12;

    // Slot memory: data valid for exactly one cycle after a strobe, junk otherwise
    always @(posedge CLK12) begin
        cyc       <= cyc + 1;
        slot_data <= slot_rd ? mem[slot_addr] : 8'($urandom);
    end

    always @(negedge CLK12) begin
        if (slot_rd === 1'b1) rd_cnt++;
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge of the first BREAK clock; decodes and checks one frame.
    task automatic run_frame(input string tag, input int n, input logic [7:0] sc,
                             input bit cont, input int drop_at);
        int          t0;
        int          rd0;
        int          d0;
        int          low;
        int          high;
        int          bad_bytes;
        int          bad_rd;
        int          busy_len;
        logic [10:0] bits;
        logic [7:0]  expb;
        t0        = cyc;
        rd0       = rd_cnt;
        d0        = done_cnt;
        bad_bytes = 0;
        bad_rd    = 0;
        chk({tag, ".start_busy"}, busy, 1);
        low = 0;
        while (dmx_data === 1'b0 && low < 4 * BRK * BC) begin
            low++;
            @(negedge CLK12);
        end
        chk({tag, ".break_len"}, low, BRK * BC);
        high = 0;
        while (dmx_data === 1'b1 && high < 4 * MAB * BC) begin
            high++;
            @(negedge CLK12);
        end
        chk({tag, ".mab_len"}, high, MAB * BC);
        for (int k = 0; k <= n; k++) begin
            if (k == drop_at) enable = 1'b0;
            if (k > 0) begin
                if (slot_rd !== 1'b1 || slot_addr !== 9'(k - 1)) bad_rd++;
            end else if (slot_rd !== 1'b0) begin
                bad_rd++;
            end
            for (int b = 0; b < 11; b++) begin
                repeat (BC / 2) @(negedge CLK12);
                bits[b] = dmx_data;
                if (slot_rd !== 1'b0 || (k > 0 && slot_addr !== 9'(k - 1))) bad_rd++;
                repeat (BC - BC / 2) @(negedge CLK12);
            end
            expb = (k == 0) ? sc : mem[k - 1];
            if (bits !== {2'b11, expb, 1'b0}) bad_bytes++;
        end
        chk({tag, ".bad_bytes"}, bad_bytes, 0);
        chk({tag, ".rd_timing"}, bad_rd, 0);
        chk({tag, ".done_time"}, cyc - t0, (BRK + MAB + 11 * (n + 1)) * BC);
        chk({tag, ".done_pulse"}, frame_done, 1);
        chk({tag, ".mtbf_line"}, dmx_data, 1);
        @(negedge CLK12);
        chk({tag, ".done_width"}, frame_done, 0);
        chk({tag, ".done_count"}, done_cnt - d0, 1);
        chk({tag, ".rd_count"}, rd_cnt - rd0, n);
        if (cont) begin
            repeat (MTBF * BC - 1) @(negedge CLK12);
            chk({tag, ".next_break"}, dmx_data, 0);
            chk({tag, ".next_busy"}, busy, 1);
        end else begin
            busy_len = 1;
            while (busy === 1'b1 && busy_len < 4 * MTBF * BC) begin
                busy_len++;
                @(negedge CLK12);
            end
            chk({tag, ".mtbf_len"}, busy_len, MTBF * BC);
            chk({tag, ".idle_line"}, dmx_data, 1);
        end
    endtask

    initial begin
        int d0;
        RESET      = 1'b1;
        enable     = 1'b1;
        num_slots  = 10'd3;
        start_code = 8'h00;
        for (int i = 0; i < 512; i++) mem[i] = 8'(i * 7 + 3) ^ 8'h5A;
        mem[0] = 8'hA5;
        mem[1] = 8'h01;
        mem[2] = 8'hFF;

        // Reset held 5 cycles with enable high
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK12);
            chk("rst.dmx", dmx_data, 1);
            chk("rst.busy", busy, 0);
            chk("rst.slot_rd", slot_rd, 0);
        end
        chk("rst.addr", slot_addr, 0);
        chk("rst.done", frame_done, 0);
        RESET = 1'b0;
        @(negedge CLK12);
        enable = 1'b0;
        run_frame("single", 3, 8'h00, 1'b0, -1);
        repeat (5) @(negedge CLK12);
        chk("idle.busy", busy, 0);

        // Back-to-back: 600 clamps to 512; new num_slots/start_code apply next frame only
        num_slots  = 10'd600;
        start_code = 8'h55;
        enable     = 1'b1;
        @(negedge CLK12);
        num_slots  = 10'd2;
        start_code = 8'hCC;
        run_frame("cont_a", 512, 8'h55, 1'b1, -1);
        run_frame("cont_b", 2, 8'hCC, 1'b0, 1);

        // Start-code-only frame
        num_slots  = 10'd0;
        start_code = 8'h17;
        enable     = 1'b1;
        @(negedge CLK12);
        enable = 1'b0;
        run_frame("zero", 0, 8'h17, 1'b0, -1);

        // Reset during slot 1 aborts; enable held restarts with a full frame
        num_slots  = 10'd3;
        start_code = 8'h3C;
        enable     = 1'b1;
        @(negedge CLK12);
        d0 = done_cnt;
        repeat ((BRK + MAB + 11) * BC + 3 * BC) @(negedge CLK12);
        chk("abort.pre_busy", busy, 1);
        RESET = 1'b1;
        @(negedge CLK12);
        chk("abort.dmx", dmx_data, 1);
        chk("abort.busy", busy, 0);
        chk("abort.slot_rd", slot_rd, 0);
        chk("abort.addr", slot_addr, 0);
        RESET = 1'b0;
        @(negedge CLK12);
        chk("abort.no_done", done_cnt - d0, 0);
        run_frame("after_rst", 3, 8'h3C, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
